// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Loader states, the pad word used for unused memory, and default sizes.
package imem_loader_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned CNT_W_DEF  = 16;

    localparam logic [31:0] FILL_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA,
        ST_CHK,
        ST_FILL,
        ST_ERR
    } loader_state_e;

    // Big-endian word: the three earlier bytes occupy the high bits.
    function automatic logic [31:0] pack_be(input logic [23:0] hi3, input logic [7:0] lo);
        return {hi3, lo};
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs a byte stream into 32-bit big-endian words.
// word_valid_o fires combinationally alongside the 4th byte of each word.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;

    // Next-state for byte position and the three held-back bytes.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_en_i) begin
            cnt_d   = cnt_q + 2'd1;
            shift_d = {shift_q[15:0], byte_i};
        end
    end

    // Byte position and holding register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    assign word_valid_o = byte_en_i && !clear_i && (cnt_q == 2'd3);
    assign word_o       = pack_be(shift_q, byte_i);

endmodule

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: header (word count N, MSB first),
// 4*N payload bytes packed big-endian and written from address 0, then
// padding with FILL_WORD up to DEPTH-1. Holds the core in reset meanwhile.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_program_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    loader_state_e     state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        hi_q, hi_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [ADDR_W:0]   fill_q, fill_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        xor_q, xor_d;
`endif

    logic              accept;
    logic              pack_en;
    logic              pack_clr;
    logic              word_valid;
    logic [31:0]       word;
    logic [CNT_W-1:0]  hdr_n;
    logic              last_word;

    assign byte_ready = (state_q == ST_HDR_HI) || (state_q == ST_HDR_LO) ||
                        (state_q == ST_DATA)   || (state_q == ST_CHK);
    assign accept     = byte_valid && byte_ready;
    assign pack_en    = accept && (state_q == ST_DATA);
    assign hdr_n      = CNT_W'({hi_q, byte_data});
    assign last_word  = (CNT_W'(widx_q) == (n_q - CNT_W'(1)));

    imem_word_packer u_packer (
        .clk_i        (Clk),
        .rst_i        (Rst),
        .clear_i      (pack_clr),
        .byte_en_i    (pack_en),
        .byte_i       (byte_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // Next-state and registered-output logic for the load sequence.
    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        done_d   = done_q;
        err_d    = err_q;
        hi_d     = hi_q;
        n_d      = n_q;
        widx_d   = widx_q;
        fill_d   = fill_q;
        pack_clr = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d    = xor_q;
`endif

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (load_start) begin
                    state_d  = ST_HDR_HI;
                    hold_d   = 1'b1;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    pack_clr = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d    = '0;
`endif
                end
            end

            ST_HDR_HI: begin
                if (accept) begin
                    hi_d    = byte_data;
                    state_d = ST_HDR_LO;
                end
            end

            ST_HDR_LO: begin
                if (accept) begin
                    n_d    = hdr_n;
                    widx_d = '0;
                    if (hdr_n > CNT_W'(DEPTH)) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (hdr_n == '0) begin
                        state_d = ST_FILL;
                        fill_d  = '0;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (word_valid) begin
                    we_d    = 1'b1;
                    addr_d  = widx_q;
                    wdata_d = word;
                    widx_d  = widx_q + 1'b1;
                    if (last_word) begin
                        fill_d = n_q[ADDR_W:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_FILL;
`endif
                    end
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    if (byte_data == xor_q) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif

            ST_FILL: begin
                // fill_q reaching DEPTH (top bit set) means every pad word is out.
                if (fill_q[ADDR_W]) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = fill_q[ADDR_W-1:0];
                    wdata_d = FILL_WORD;
                    fill_d  = fill_q + 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept && (state_q != ST_CHK)) begin
            xor_d = xor_q ^ byte_data;
        end
`endif
    end

    // State and output registers; reset clears everything but memory.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hi_q    <= '0;
            n_q     <= '0;
            widx_q  <= '0;
            fill_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hi_q    <= hi_d;
            n_q     <= n_d;
            widx_q  <= widx_d;
            fill_q  <= fill_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = hold_q;
    assign load_done = done_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Testbench for imem_program_loader. Honours IMEM_LOADER_CHECKSUM_EN.
module tb_imem_program_loader;

    localparam int DEPTH = 64;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    imem_program_loader #(.ADDR_W(6), .CNT_W(16)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 Clk = ~Clk;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CK_EN = 1;
`else
    localparam int CK_EN = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Edge counter and write monitor.
    int          cyc = 0;
    always @(posedge Clk) cyc++;

    bit          mon_en = 0;
    int          mon_n = 0;
    int          stream_len = 0;
    int          acc_idx = 0;
    bit          exp_wr = 0;
    int          exp_wr_addr = 0;
    int          words_seen = 0;
    int          fill_next = 0;
    int          we_cnt = 0;
    int          last_we_cyc = 0;
    bit          wr_flag [DEPTH];
    logic [31:0] mem_model [DEPTH];

    always @(negedge Clk) begin
        if (mon_en) begin
            if (exp_wr) begin
                chk("word_we", 32'(mem_we), 32'd1);
                chk("word_addr", 32'(mem_addr), 32'(exp_wr_addr));
                if (mem_we) words_seen++;
                exp_wr = 0;
            end else if (mem_we) begin
                chk("fill_after_words", 32'(words_seen), 32'(mon_n));
                chk("fill_addr", 32'(mem_addr), 32'(fill_next));
                chk("fill_data", mem_wdata, 32'hFFFF_FFFF);
                fill_next++;
            end
            if (mem_we) begin
                wr_flag[mem_addr]   = 1'b1;
                mem_model[mem_addr] = mem_wdata;
                we_cnt++;
                last_we_cyc = cyc;
            end
            if (byte_valid && byte_ready) begin
                int k;
                k = acc_idx;
                acc_idx++;
                chk("no_overrun", 32'(k < stream_len), 32'd1);
                if (k >= 2 && k < 2 + 4 * mon_n && ((k - 2) % 4) == 3) begin
                    exp_wr      = 1;
                    exp_wr_addr = (k - 2) / 4;
                end
            end
        end
    end

    typedef struct {
        int n;
        int stall;       // 0 continuous, 1 pattern 1,0,0, 2 random
        bit bad_ck;
        bit fixed;       // use the known 2-word image
        bit extra_start; // stray load_start pulse mid-stream
        bit exp_err;
        int exp_we;
    } vec_t;

    vec_t        tbl[$];
    logic [7:0]  fixed_b [8];

    task automatic run_load(input vec_t v, input int abort_after);
        logic [7:0]  strm[$];
        logic [7:0]  pay [256];
        logic [31:0] exp_img [DEPTH];
        logic [15:0] n16;
        logic [7:0]  ck;
        int          cycles, accepted, p, mism, start_cyc, done_cyc, lat_last;
        bit          acc, pulsed, vbit;

        n16 = 16'(v.n);
        strm.push_back(n16[15:8]);
        strm.push_back(n16[7:0]);
        ck = n16[15:8] ^ n16[7:0];
        for (int i = 0; i < DEPTH; i++) exp_img[i] = 32'hFFFF_FFFF;
        if (v.n <= DEPTH) begin
            for (int i = 0; i < 4 * v.n; i++) begin
                pay[i] = v.fixed ? fixed_b[i % 8] : 8'($urandom);
                strm.push_back(pay[i]);
                ck ^= pay[i];
            end
            for (int w = 0; w < v.n; w++)
                exp_img[w] = {pay[4*w], pay[4*w+1], pay[4*w+2], pay[4*w+3]};
            if (CK_EN != 0 && v.n > 0)
                strm.push_back(v.bad_ck ? ((ck == 8'h00) ? 8'h01 : 8'h00) : ck);
        end

        mon_n      = v.n;
        stream_len = strm.size();
        acc_idx    = 0;
        exp_wr     = 0;
        words_seen = 0;
        fill_next  = v.n;
        we_cnt     = 0;
        for (int i = 0; i < DEPTH; i++) wr_flag[i] = 1'b0;
        mon_en     = 1;

        @(posedge Clk); #1 load_start = 1'b1;
        @(negedge Clk); start_cyc = cyc + 1;
        @(posedge Clk); #1 load_start = 1'b0;

        cycles = 0; accepted = 0; p = 0; pulsed = 0;
        while (!(load_done || load_err) && cycles < 4000) begin
            case (v.stall)
                0:       vbit = 1'b1;
                1:       vbit = (p % 3) == 0;
                default: vbit = 1'($urandom);
            endcase
            p++;
            if (strm.size() > 0) begin
                byte_valid = vbit;
                byte_data  = strm[0];
            end else begin
                byte_valid = 1'b1;
                byte_data  = 8'hA5;
            end
            if (v.extra_start && !pulsed && accepted == 6) begin
                load_start = 1'b1;
                pulsed     = 1;
            end else begin
                load_start = 1'b0;
            end
            @(negedge Clk);
            acc = byte_valid && byte_ready;
            if (abort_after >= 0 && accepted >= abort_after) begin
                Rst = 1'b1;
                #1;
                chk("rst_byte_ready", 32'(byte_ready), 32'd0);
                chk("rst_mem_we", 32'(mem_we), 32'd0);
                chk("rst_mem_addr", 32'(mem_addr), 32'd0);
                chk("rst_mem_wdata", mem_wdata, 32'd0);
                chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
                chk("rst_load_done", 32'(load_done), 32'd0);
                chk("rst_load_err", 32'(load_err), 32'd0);
                mon_en     = 0;
                byte_valid = 1'b0;
                load_start = 1'b0;
                @(posedge Clk); #1 Rst = 1'b0;
                return;
            end
            @(posedge Clk);
            if (acc) begin
                void'(strm.pop_front());
                accepted++;
            end
            #1;
            cycles++;
        end
        done_cyc   = cyc;
        byte_valid = 1'b0;
        load_start = 1'b0;
        chk("load_finished_in_time", 32'(cycles < 4000), 32'd1);
        @(negedge Clk);
        mon_en = 0;

        chk("load_done", 32'(load_done), 32'(!v.exp_err));
        chk("load_err", 32'(load_err), 32'(v.exp_err));
        chk("cpu_hold", 32'(cpu_hold), 32'(v.exp_err));
        chk("byte_ready_after", 32'(byte_ready), 32'd0);
        chk("we_count", 32'(we_cnt), 32'(v.exp_we));
        mism = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < v.exp_we) begin
                if (!wr_flag[i] || mem_model[i] !== exp_img[i]) begin
                    if (mism == 0)
                        $display("  image word %0d: got 0x%0h expected 0x%0h", i, mem_model[i], exp_img[i]);
                    mism++;
                end
            end else if (wr_flag[i]) begin
                mism++;
            end
        end
        chk("image_mismatches", 32'(mism), 32'd0);

        if (v.stall == 0 && !v.exp_err) begin
            if (v.n == DEPTH) lat_last = 2 + 4 * v.n;
            else lat_last = 2 + 4 * v.n + ((v.n > 0) ? CK_EN : 0) + (DEPTH - v.n);
            chk("last_write_cycle", 32'(last_we_cyc - start_cyc), 32'(lat_last));
            chk("done_cycle", 32'(done_cyc - start_cyc),
                32'(2 + 4 * v.n + ((v.n > 0) ? CK_EN : 0) + (DEPTH - v.n) + 1));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t hv;
        fixed_b = '{8'h20, 8'h02, 8'h00, 8'h05, 8'h20, 8'h03, 8'h00, 8'h0C};

        //                n   stall bad fixed xst err  we
        tbl.push_back('{  2,  0,    0,  1,    0,  0,   64});
        tbl.push_back('{  0,  0,    0,  0,    0,  0,   64});
        tbl.push_back('{ 65,  0,    0,  0,    0,  1,    0});
        tbl.push_back('{  2,  1,    0,  1,    1,  0,   64});
        tbl.push_back('{ 64,  2,    0,  0,    0,  0,   64});
        tbl.push_back('{ 64,  0,    0,  0,    0,  0,   64});
        tbl.push_back('{  1,  2,    0,  0,    0,  0,   64});
        tbl.push_back('{ 63,  0,    0,  0,    1,  0,   64});
`ifdef IMEM_LOADER_CHECKSUM_EN
        tbl.push_back('{  2,  0,    1,  1,    0,  1,    2});
        tbl.push_back('{  5,  2,    1,  0,    0,  1,    5});
`endif
        tbl.push_back('{  3,  2,    0,  0,    0,  0,   64});

        repeat (3) @(posedge Clk);
        #1;
        chk("reset_byte_ready", 32'(byte_ready), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("reset_load_done", 32'(load_done), 32'd0);
        chk("reset_load_err", 32'(load_err), 32'd0);
        Rst = 1'b0;

        foreach (tbl[i]) run_load(tbl[i], -1);

        // Reset after 5 payload bytes, then a clean reload from address 0.
        hv = '{2, 0, 0, 1, 0, 0, 64};
        run_load(hv, 7);
        run_load(hv, -1);
        chk("known_word0", mem_model[0], 32'h2002_0005);
        chk("known_word1", mem_model[1], 32'h2003_000C);
        chk("known_word2", mem_model[2], 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
